fdiv_seq: RTL and testbench

FDIV_SEQ -- requirements
Module: fdiv_seq

---
 rtl/fp_pkg.sv | 17 +
 rtl/fdiv_step.sv | 21 ++
 rtl/fdiv_seq.sv | 171 +++++++++++++++++
 tb/tb_fdiv_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants and sequencer states for the divider and multiplier.
// Constants describe the default 8-bit exponent format.
package fp_pkg;

    localparam int FP_EXP_WIDTH = 8;

    // Most negative exponent marks canonical zero; most positive is the saturation value.
    localparam logic [FP_EXP_WIDTH-1:0] EXP_ZERO = {1'b1, {(FP_EXP_WIDTH-1){1'b0}}};
    localparam logic [FP_EXP_WIDTH-1:0] EXP_MAX  = {1'b0, {(FP_EXP_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } fp_state_t;

endpackage

// File: rtl/fdiv_step.sv
// One restoring-division iteration: compare, conditional subtract, shift left.
// Purely combinational; no backpressure.
module fdiv_step #(
    parameter int FRAC_WIDTH = 40
) (
    input  logic [FRAC_WIDTH:0]   rem,
    input  logic [FRAC_WIDTH-1:0] divisor,
    output logic                  q_bit,
    output logic [FRAC_WIDTH:0]   rem_next
);

    logic [FRAC_WIDTH:0] div_ext;
    logic [FRAC_WIDTH:0] diff;

    assign div_ext  = {1'b0, divisor};
    assign q_bit    = (rem >= div_ext);
    assign diff     = q_bit ? (rem - div_ext) : rem;
    // diff is always below the divisor, so the shift cannot lose a set bit.
    assign rem_next = diff << 1;

endmodule

// File: rtl/fdiv_seq.sv
// Sequential FP divider, one quotient bit per cycle; result valid FRAC_WIDTH cycles after accept.
// Accepts only when idle; the result is held until the downstream takes it.
module fdiv_seq
    import fp_pkg::*;
#(
    parameter int FRAC_WIDTH = 40,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_sign_a,
    input  logic [EXP_WIDTH-1:0]  i_exp_a,
    input  logic [FRAC_WIDTH-1:0] i_frac_a,
    input  logic                  i_sign_b,
    input  logic [EXP_WIDTH-1:0]  i_exp_b,
    input  logic [FRAC_WIDTH-1:0] i_frac_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sign_c,
    output logic [EXP_WIDTH-1:0]  o_exp_c,
    output logic [FRAC_WIDTH-1:0] o_frac_c,
    output logic                  o_div0,
    output logic                  o_ovf
);

    localparam int CW = $clog2(FRAC_WIDTH + 1);
    localparam logic [EXP_WIDTH-1:0] EXP_ZERO_W = {1'b1, {(EXP_WIDTH-1){1'b0}}};
    localparam logic [EXP_WIDTH-1:0] EXP_MAX_W  = {1'b0, {(EXP_WIDTH-1){1'b1}}};
    localparam logic signed [EXP_WIDTH:0] EXP_HI = {2'b00, {(EXP_WIDTH-1){1'b1}}};
    localparam logic signed [EXP_WIDTH:0] EXP_LO = {2'b11, {(EXP_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST_ITER = CW'(FRAC_WIDTH - 1);

    fp_state_t state_q, state_d;

    logic                         sign_q;
    logic signed [EXP_WIDTH:0]    exp_q;
    logic [FRAC_WIDTH:0]          rem_q;
    logic [FRAC_WIDTH-1:0]        div_q;
    logic [FRAC_WIDTH-1:0]        quo_q;
    logic [CW-1:0]                cnt_q;
    logic                         a_zero_q;
    logic                         b_zero_q;

    logic                         a_ge;
    logic signed [EXP_WIDTH:0]    ea_x, eb_x, exp_diff, exp_pre;
    logic                         q_bit;
    logic [FRAC_WIDTH:0]          rem_next;
    logic [FRAC_WIDTH-1:0]        quo_final;
    logic                         last_iter;

    logic [EXP_WIDTH-1:0]         res_exp;
    logic [FRAC_WIDTH-1:0]        res_frac;
    logic                         res_div0;
    logic                         res_ovf;

    assign o_ready = (state_q == ST_IDLE);

    // Pre-alignment keeps the quotient in [1,2) so its MSB is always set.
    assign a_ge     = (i_frac_a >= i_frac_b);
    assign ea_x     = {i_exp_a[EXP_WIDTH-1], i_exp_a};
    assign eb_x     = {i_exp_b[EXP_WIDTH-1], i_exp_b};
    assign exp_diff = ea_x - eb_x;
    assign exp_pre  = a_ge ? exp_diff : exp_diff - {{EXP_WIDTH{1'b0}}, 1'b1};

    fdiv_step #(.FRAC_WIDTH(FRAC_WIDTH)) u_step (
        .rem      (rem_q),
        .divisor  (div_q),
        .q_bit    (q_bit),
        .rem_next (rem_next)
    );

    assign quo_final = {quo_q[FRAC_WIDTH-2:0], q_bit};
    assign last_iter = (cnt_q == LAST_ITER);

    // Divide-by-zero wins over a zero dividend; range checks apply only to real quotients.
    always_comb begin
        res_exp  = exp_q[EXP_WIDTH-1:0];
        res_frac = quo_final;
        res_div0 = 1'b0;
        res_ovf  = 1'b0;
        if (b_zero_q) begin
            res_exp  = EXP_MAX_W;
            res_frac = '1;
            res_div0 = 1'b1;
        end else if (a_zero_q) begin
            res_exp  = EXP_ZERO_W;
            res_frac = '0;
        end else if (exp_q > EXP_HI) begin
            res_exp  = EXP_MAX_W;
            res_frac = '1;
            res_ovf  = 1'b1;
        end else if (exp_q < EXP_LO) begin
            res_exp  = EXP_ZERO_W;
            res_frac = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid)   state_d = ST_DIV;
            ST_DIV:  if (last_iter) state_d = ST_DONE;
            ST_DONE: if (i_ready)   state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            a_zero_q <= 1'b0;
            b_zero_q <= 1'b0;
            o_valid  <= 1'b0;
            o_sign_c <= 1'b0;
            o_exp_c  <= '0;
            o_frac_c <= '0;
            o_div0   <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        sign_q   <= i_sign_a ^ i_sign_b;
                        exp_q    <= exp_pre;
                        rem_q    <= a_ge ? {1'b0, i_frac_a} : {i_frac_a, 1'b0};
                        div_q    <= i_frac_b;
                        quo_q    <= '0;
                        cnt_q    <= '0;
                        a_zero_q <= ~i_frac_a[FRAC_WIDTH-1];
                        b_zero_q <= ~i_frac_b[FRAC_WIDTH-1];
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_next;
                    quo_q <= quo_final;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        cnt_q    <= '0;
                        o_valid  <= 1'b1;
                        o_sign_c <= sign_q;
                        o_exp_c  <= res_exp;
                        o_frac_c <= res_frac;
                        o_div0   <= res_div0;
                        o_ovf    <= res_ovf;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_div0  <= 1'b0;
                        o_ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: hand-computed quotients, special cases, stall, reset and back-to-back.
module tb_fdiv_seq;

    localparam int FW = 40;
    localparam int EW = 8;
    localparam int NV = 12;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic          i_sign_a = 1'b0, i_sign_b = 1'b0;
    logic [EW-1:0] i_exp_a = '0, i_exp_b = '0;
    logic [FW-1:0] i_frac_a = '0, i_frac_b = '0;
    logic          o_ready, o_valid, o_sign_c, o_div0, o_ovf;
    logic [EW-1:0] o_exp_c;
    logic [FW-1:0] o_frac_c;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic          sa;
        logic [EW-1:0] ea;
        logic [FW-1:0] fa;
        logic          sb;
        logic [EW-1:0] eb;
        logic [FW-1:0] fb;
        logic [50:0]   res;   // {sign, exp, frac, div0, ovf}
    } vec_t;

    vec_t vec [NV];

    wire [50:0] res_now = {o_sign_c, o_exp_c, o_frac_c, o_div0, o_ovf};

    fdiv_seq #(.FRAC_WIDTH(FW), .EXP_WIDTH(EW)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sign_a (i_sign_a),
        .i_exp_a  (i_exp_a),
        .i_frac_a (i_frac_a),
        .i_sign_b (i_sign_b),
        .i_exp_b  (i_exp_b),
        .i_frac_b (i_frac_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sign_c (o_sign_c),
        .o_exp_c  (o_exp_c),
        .o_frac_c (o_frac_c),
        .o_div0   (o_div0),
        .o_ovf    (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic init_vectors();
        vec[0]  = '{1'b0, 8'h03, 40'hC000000000, 1'b0, 8'h01, 40'h8000000000, {1'b0, 8'h02, 40'hC000000000, 2'b00}};
        vec[1]  = '{1'b0, 8'h00, 40'h8000000000, 1'b1, 8'h00, 40'hC000000000, {1'b1, 8'hFF, 40'hAAAAAAAAAA, 2'b00}};
        vec[2]  = '{1'b1, 8'h05, 40'h8000000000, 1'b0, 8'h02, 40'h0000000000, {1'b1, 8'h7F, 40'hFFFFFFFFFF, 2'b10}};
        vec[3]  = '{1'b0, 8'h00, 40'h0000000000, 1'b0, 8'h00, 40'h0000000000, {1'b0, 8'h7F, 40'hFFFFFFFFFF, 2'b10}};
        vec[4]  = '{1'b0, 8'h10, 40'h0000000000, 1'b1, 8'h00, 40'h8000000000, {1'b1, 8'h80, 40'h0000000000, 2'b00}};
        vec[5]  = '{1'b0, 8'h7F, 40'h8000000000, 1'b0, 8'hFF, 40'h8000000000, {1'b0, 8'h7F, 40'hFFFFFFFFFF, 2'b01}};
        vec[6]  = '{1'b0, 8'h80, 40'h8000000000, 1'b0, 8'h01, 40'h8000000000, {1'b0, 8'h80, 40'h0000000000, 2'b00}};
        vec[7]  = '{1'b0, 8'h7F, 40'h8000000000, 1'b0, 8'h00, 40'h8000000000, {1'b0, 8'h7F, 40'h8000000000, 2'b00}};
        vec[8]  = '{1'b0, 8'h80, 40'h8000000000, 1'b0, 8'h00, 40'h8000000000, {1'b0, 8'h80, 40'h8000000000, 2'b00}};
        vec[9]  = '{1'b1, 8'h00, 40'h8000000000, 1'b1, 8'h00, 40'h8000000000, {1'b0, 8'h00, 40'h8000000000, 2'b00}};
        vec[10] = '{1'b0, 8'h01, 40'hC000000000, 1'b0, 8'h01, 40'h7FFFFFFFFF, {1'b0, 8'h7F, 40'hFFFFFFFFFF, 2'b10}};
        vec[11] = '{1'b0, 8'h00, 40'hC000000000, 1'b0, 8'h00, 40'hA000000000, {1'b0, 8'h00, 40'h9999999999, 2'b00}};
    endtask

    task automatic set_operands(input vec_t v);
        i_sign_a = v.sa; i_exp_a = v.ea; i_frac_a = v.fa;
        i_sign_b = v.sb; i_exp_b = v.eb; i_frac_b = v.fb;
    endtask

    task automatic scramble_operands();
        i_sign_a = 1'($urandom); i_exp_a = 8'($urandom); i_frac_a = {8'($urandom), 32'($urandom)};
        i_sign_b = 1'($urandom); i_exp_b = 8'($urandom); i_frac_b = {8'($urandom), 32'($urandom)};
    endtask

    // Counts rising edges from the current point until o_valid is seen; capped at 200.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    // Present one operand pair, return edges from acceptance to o_valid.
    task automatic run_op(input vec_t v, output int lat);
        int guard = 0;
        while (!o_ready && guard < 200) begin
            @(posedge i_clk); #1;
            guard++;
        end
        set_operands(v);
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        scramble_operands();
        wait_valid(lat);
    endtask

    task automatic take();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
        set_operands(vec[0]);
        repeat (3) @(posedge i_clk);
        #1;
        n_cmp++;
        if ({o_valid, o_ready, o_div0, o_ovf, o_sign_c, o_exp_c, o_frac_c} !== {4'b0100, 1'b0, 8'h00, 40'h0}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b r=%b d0=%b ovf=%b s=%b e=%h f=%h want v=0 r=1 d0=0 ovf=0 s=0 e=00 f=0",
                     o_valid, o_ready, o_div0, o_ovf, o_sign_c, o_exp_c, o_frac_c);
        end
        i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        @(posedge i_clk); #1;
        n_cmp++;
        if ({o_ready, o_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_priority: got ready=%b valid=%b want ready=1 valid=0", o_ready, o_valid);
        end
    endtask

    task automatic test_vectors();
        int lat;
        for (int i = 0; i < NV; i++) begin
            run_op(vec[i], lat);
            n_cmp++;
            if (lat !== FW) begin
                n_err++;
                $display("FAIL latency_v%0d: got %0d want %0d", i, lat, FW);
            end
            n_cmp++;
            if (res_now !== vec[i].res) begin
                n_err++;
                $display("FAIL result_v%0d: got %h want %h", i, res_now, vec[i].res);
            end
            take();
            n_cmp++;
            if ({o_valid, o_ready, o_div0, o_ovf} !== 4'b0100) begin
                n_err++;
                $display("FAIL after_take_v%0d: got valid=%b ready=%b d0=%b ovf=%b want 0 1 0 0",
                         i, o_valid, o_ready, o_div0, o_ovf);
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        run_op(vec[5], lat);
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if ({o_valid, o_ready, res_now} !== {2'b10, vec[5].res}) begin
                n_err++;
                $display("FAIL stall_c%0d: got valid=%b ready=%b res=%h want 1 0 %h", c, o_valid, o_ready, res_now, vec[5].res);
            end
            @(posedge i_clk); #1;
        end
        take();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: got valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        set_operands(vec[0]);
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (19) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        n_cmp++;
        if ({o_ready, o_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_mid_ready: got ready=%b valid=%b want 1 0", o_ready, o_valid);
        end
        for (int c = 0; c < 60; c++) begin
            @(posedge i_clk); #1;
            if (o_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_mid_no_result: got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        set_operands(vec[0]);
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        set_operands(vec[11]);
        wait_valid(lat);
        n_cmp++;
        if (lat !== FW || res_now !== vec[0].res) begin
            n_err++;
            $display("FAIL b2b_first: got lat=%0d res=%h want lat=%0d res=%h", lat, res_now, FW, vec[0].res);
        end
        take();
        n_cmp++;
        if ({o_ready, o_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_ready_after_take: got ready=%b valid=%b want 1 0", o_ready, o_valid);
        end
        @(posedge i_clk); #1;
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_accept: got ready=%b want 0", o_ready);
        end
        i_valid = 1'b0;
        scramble_operands();
        wait_valid(lat);
        n_cmp++;
        if (lat !== FW || res_now !== vec[11].res) begin
            n_err++;
            $display("FAIL b2b_second: got lat=%0d res=%h want lat=%0d res=%h", lat, res_now, FW, vec[11].res);
        end
        take();
    endtask

    initial begin
        init_vectors();
        test_reset();
        test_vectors();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
